span_scan_risk_engine: RTL and testbench



---
 rtl/span_scan_risk_engine_pkg.sv | 31 +++
 rtl/span_scan_risk_engine_if.sv | 23 ++
 rtl/span_scan_risk_engine_mac.sv | 64 ++++++
 rtl/span_scan_risk_engine.sv | 177 +++++++++++++++++
 tb/tb_span_scan_risk_engine.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/span_scan_risk_engine_pkg.sv
// Shared register offsets, FSM states and width helpers for the
// portfolio scanning-risk engine.
package span_scan_risk_engine_pkg;

    localparam int OFF_CTRL     = 0;
    localparam int OFF_STATUS   = 1;
    localparam int OFF_NUM_POS  = 2;
    localparam int OFF_POS_SEL  = 3;
    localparam int OFF_QTY      = 4;
    localparam int OFF_SCEN_SEL = 5;
    localparam int OFF_RA_DATA  = 6;
    localparam int OFF_RISK_LO  = 8;
    localparam int OFF_RISK_HI  = 9;
    localparam int OFF_WORST    = 10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic int res_width(input int data_w);
        return 2 * data_w;
    endfunction

    // Enough headroom to sum MAX_POS full-scale products without wrapping.
    function automatic int acc_width(input int data_w, input int max_pos);
        return 2 * data_w + $clog2(max_pos);
    endfunction

endpackage

// File: rtl/span_scan_risk_engine_if.sv
// Avalon-style register slave bus shared with span_cme.
interface span_scan_risk_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] offset;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              irq;

    modport master (
        output chipselect, write, read, offset, writeData,
        input  readData, irq
    );

    modport slave (
        input  chipselect, write, read, offset, writeData,
        output readData, irq
    );
endinterface

// File: rtl/span_scan_risk_engine_mac.sv
// Signed multiply-accumulate over positions, per-scenario max tracking and
// saturation of the floored maximum loss to RES_W.
module span_scan_risk_engine_mac
    import span_scan_risk_engine_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_POS  = 8,
    parameter int RES_W    = 32,
    parameter int SW       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     last,
    input  logic [SW-1:0]            scen,
    input  logic signed [DATA_W-1:0] qty,
    input  logic signed [DATA_W-1:0] ra,
    output logic [RES_W-1:0]         risk,
    output logic                     sat,
    output logic [SW-1:0]            worst
);
    localparam int ACC_W = acc_width(DATA_W, MAX_POS);
    localparam logic signed [ACC_W-1:0] RES_MAX =
        {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc, maxv, sum;

    assign prod = qty * ra;
    assign sum  = acc + ACC_W'(prod);

    // Scenario 0 always seeds the max, so maxv is the true maximum loss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            maxv  <= '0;
            worst <= '0;
        end else if (clr) begin
            acc   <= '0;
            maxv  <= '0;
            worst <= '0;
        end else if (en) begin
            acc <= last ? '0 : sum;
            if (last && (scen == '0 || sum > maxv)) begin
                maxv  <= sum;
                worst <= scen;
            end
        end
    end

    always_comb begin
        risk = '0;
        sat  = 1'b0;
        if (maxv[ACC_W-1]) begin
            risk = '0;
        end else if (maxv > RES_MAX) begin
            risk = RES_MAX[RES_W-1:0];
            sat  = 1'b1;
        end else begin
            risk = maxv[RES_W-1:0];
        end
    end
endmodule

// File: rtl/span_scan_risk_engine.sv
// Scanning-risk engine: register file, position/scenario sequencer and
// result registers around the MAC datapath.
module span_scan_risk_engine
    import span_scan_risk_engine_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_SCEN = 16,
    parameter int MAX_POS  = 8,
    parameter int ADDR_W   = 6,
    parameter int RES_W    = res_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    span_scan_risk_engine_if.slave bus
);
    localparam int SW  = $clog2(NUM_SCEN);
    localparam int PW  = (MAX_POS > 1) ? $clog2(MAX_POS) : 1;
    localparam int NPW = $clog2(MAX_POS + 1);

    state_e state, state_n;

    logic [NPW-1:0]           num_pos;
    logic [PW-1:0]            pos_sel, p_cnt;
    logic [SW-1:0]            scen_sel, s_cnt;
    logic signed [DATA_W-1:0] qty [MAX_POS];
    logic signed [DATA_W-1:0] ra  [MAX_POS][NUM_SCEN];

    logic              irq_en, done, ovf;
    logic [RES_W-1:0]  risk, mac_risk;
    logic [SW-1:0]     worst, mac_worst;
    logic              mac_sat;
    logic [DATA_W-1:0] rdata;

    logic wr_en, rd_en, ctrl_wr, clr_cmd, start_cmd, busy, cfg_wr;
    logic last_pos, last_scen;

    assign wr_en     = bus.chipselect & bus.write;
    assign rd_en     = bus.chipselect & bus.read;
    assign busy      = (state != IDLE);
    assign cfg_wr    = wr_en & ~busy;
    assign ctrl_wr   = wr_en && (bus.offset == ADDR_W'(OFF_CTRL));
    assign clr_cmd   = ctrl_wr & bus.writeData[1];
    assign start_cmd = ctrl_wr & bus.writeData[0] & ~bus.writeData[1] & ~busy;
    assign last_pos  = (NPW'(p_cnt) == num_pos - NPW'(1));
    assign last_scen = (s_cnt == SW'(NUM_SCEN - 1));
    assign bus.irq   = done & irq_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start_cmd) state_n = (num_pos == '0) ? DONE : CALC;
            CALC: if (last_pos && last_scen) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clr_cmd) state_n = IDLE;
    end

    // Scenario is the outer loop, position the inner one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_cnt <= '0;
            s_cnt <= '0;
        end else if (clr_cmd || start_cmd) begin
            p_cnt <= '0;
            s_cnt <= '0;
        end else if (state == CALC) begin
            if (last_pos) begin
                p_cnt <= '0;
                s_cnt <= s_cnt + SW'(1);
            end else begin
                p_cnt <= p_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_pos  <= '0;
            pos_sel  <= '0;
            scen_sel <= '0;
            for (int p = 0; p < MAX_POS; p++) begin
                qty[p] <= '0;
                for (int s = 0; s < NUM_SCEN; s++) ra[p][s] <= '0;
            end
        end else if (cfg_wr) begin
            case (bus.offset)
                ADDR_W'(OFF_NUM_POS):
                    num_pos <= (bus.writeData > DATA_W'(MAX_POS)) ? NPW'(MAX_POS)
                                                                  : NPW'(bus.writeData);
                ADDR_W'(OFF_POS_SEL):  pos_sel  <= PW'(bus.writeData % DATA_W'(MAX_POS));
                ADDR_W'(OFF_QTY):      qty[pos_sel] <= bus.writeData;
                ADDR_W'(OFF_SCEN_SEL): scen_sel <= SW'(bus.writeData);
                ADDR_W'(OFF_RA_DATA): begin
                    ra[pos_sel][scen_sel] <= bus.writeData;
                    scen_sel              <= scen_sel + SW'(1);
                end
                default: ;
            endcase
        end
    end

    // A clear write leaves irq_en alone so an abort never silences the host.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            risk   <= '0;
            worst  <= '0;
        end else begin
            if (ctrl_wr && !bus.writeData[1]) irq_en <= bus.writeData[2];
            if (clr_cmd) begin
                done  <= 1'b0;
                ovf   <= 1'b0;
                risk  <= '0;
                worst <= '0;
            end else if (start_cmd) begin
                done <= 1'b0;
                ovf  <= 1'b0;
            end else if (state == DONE) begin
                done  <= 1'b1;
                ovf   <= mac_sat;
                risk  <= mac_risk;
                worst <= mac_worst;
            end else if (wr_en && bus.offset == ADDR_W'(OFF_STATUS) && bus.writeData[1]) begin
                done <= 1'b0;
            end
        end
    end

    span_scan_risk_engine_mac #(
        .DATA_W (DATA_W),
        .MAX_POS(MAX_POS),
        .RES_W  (RES_W),
        .SW     (SW)
    ) u_mac (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_cmd | start_cmd),
        .en   (state == CALC),
        .last (last_pos),
        .scen (s_cnt),
        .qty  (qty[p_cnt]),
        .ra   (ra[p_cnt][s_cnt]),
        .risk (mac_risk),
        .sat  (mac_sat),
        .worst(mac_worst)
    );

    always_comb begin
        rdata = '0;
        case (bus.offset)
            ADDR_W'(OFF_CTRL):     rdata[2]   = irq_en;
            ADDR_W'(OFF_STATUS):   rdata[2:0] = {ovf, done, busy};
            ADDR_W'(OFF_NUM_POS):  rdata = DATA_W'(num_pos);
            ADDR_W'(OFF_POS_SEL):  rdata = DATA_W'(pos_sel);
            ADDR_W'(OFF_QTY):      rdata = qty[pos_sel];
            ADDR_W'(OFF_SCEN_SEL): rdata = DATA_W'(scen_sel);
            ADDR_W'(OFF_RA_DATA):  rdata = ra[pos_sel][scen_sel];
            ADDR_W'(OFF_RISK_LO):  rdata = risk[DATA_W-1:0];
            ADDR_W'(OFF_RISK_HI):  rdata = DATA_W'(risk[RES_W-1:DATA_W]);
            ADDR_W'(OFF_WORST):    rdata = DATA_W'(worst);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      bus.readData <= '0;
        else if (rd_en) bus.readData <= rdata;
    end
endmodule

// File: tb/tb_span_scan_risk_engine.sv
// Self-checking bench: directed table, corner sequences and randomized
// portfolios checked against a plain-arithmetic scanning-risk model.
module tb_span_scan_risk_engine;
    localparam int NP = 8;
    localparam int NS = 16;
    localparam int R_CTRL = 0, R_STATUS = 1, R_NUM_POS = 2, R_POS_SEL = 3, R_QTY = 4;
    localparam int R_SCEN_SEL = 5, R_RA = 6, R_LO = 8, R_HI = 9, R_WORST = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    span_scan_risk_engine_if bus ();

    span_scan_risk_engine dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int qty_m [NP];
    int ra_m  [NP][NS];

    typedef struct {
        int np, qa, qb, base, slope, rb;
        int lo, hi, wst, ovf;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input int off, input int data);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.offset     = 6'(off);
        bus.writeData  = 16'(data);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic rd(input int off, output int data);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.offset     = 6'(off);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        data = int'(bus.readData);
    endtask

    task automatic load_all(input int np);
        wr(R_NUM_POS, np);
        for (int p = 0; p < NP; p++) begin
            wr(R_POS_SEL, p);
            wr(R_QTY, qty_m[p]);
            wr(R_SCEN_SEL, 0);
            for (int s = 0; s < NS; s++) wr(R_RA, ra_m[p][s]);
        end
    endtask

    // Worst loss over scenarios, first index on ties, floored and saturated.
    task automatic model(input int np, output int lo, output int hi,
                         output int wst, output int ovf);
        longint loss, mx, r;
        int n;
        n = (np > NP) ? NP : np;
        mx = 0;
        wst = 0;
        if (n > 0) begin
            for (int s = 0; s < NS; s++) begin
                loss = 0;
                for (int p = 0; p < n; p++) loss += longint'(qty_m[p]) * longint'(ra_m[p][s]);
                if (s == 0 || loss > mx) begin
                    mx  = loss;
                    wst = s;
                end
            end
        end
        r = (mx < 0) ? 0 : mx;
        ovf = (r > 64'sd2147483647) ? 1 : 0;
        if (ovf == 1) r = 64'sd2147483647;
        lo = int'(r & 64'hFFFF);
        hi = int'((r >> 16) & 64'hFFFF);
    endtask

    task automatic run_check(input string nm, input int np, input int elo, input int ehi,
                             input int ewst, input int eovf);
        int cnt, v, npe;
        npe = (np > NP) ? NP : np;
        wr(R_CTRL, 5);
        cnt = 0;
        while (!bus.irq && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check({nm, "_cycles"}, cnt, (npe == 0) ? 1 : NS * npe + 1);
        rd(R_STATUS, v); check({nm, "_status"}, v, eovf * 4 + 2);
        rd(R_LO, v);     check({nm, "_risk_lo"}, v, elo);
        rd(R_HI, v);     check({nm, "_risk_hi"}, v, ehi);
        rd(R_WORST, v);  check({nm, "_worst"}, v, ewst);
    endtask

    task automatic fill(input vec_t t);
        for (int p = 0; p < NP; p++) begin
            qty_m[p] = (p == 0) ? t.qa : t.qb;
            for (int s = 0; s < NS; s++) ra_m[p][s] = (p == 0) ? t.base + t.slope * s : t.rb;
        end
    endtask

    initial begin
        int v, lo, hi, wst, ovf, np;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.offset     = '0;
        bus.writeData  = '0;

        tbl[0] = '{2, 3, -2, 0, 1, 5, 35, 0, 15, 0};
        tbl[1] = '{1, 1, 1, -4, 0, -4, 0, 0, 0, 0};
        tbl[2] = '{8, 32767, 32767, 32767, 0, 32767, 65535, 32767, 0, 1};
        tbl[3] = '{4, -100, 7, 20, -3, 50, 3550, 0, 15, 0};
        tbl[4] = '{2, 1000, -1000, 100, 0, 30, 4464, 1, 0, 0};
        tbl[5] = '{200, -5, 1, -7, 2, 0, 35, 0, 0, 0};

        repeat (2) @(negedge clk);
        check("reset_readdata", int'(bus.readData), 0);
        check("reset_irq", int'(bus.irq), 0);
        reset = 1'b0;
        @(negedge clk);
        rd(R_STATUS, v); check("reset_status", v, 0);
        rd(R_LO, v);     check("reset_risk_lo", v, 0);

        for (int i = 0; i < 6; i++) begin
            fill(tbl[i]);
            load_all(tbl[i].np);
            run_check($sformatf("tbl%0d", i), tbl[i].np, tbl[i].lo, tbl[i].hi,
                      tbl[i].wst, tbl[i].ovf);
        end

        // Saturated run raises irq until W1 to done; ovf stays sticky.
        fill(tbl[2]);
        load_all(8);
        run_check("sat", 8, 65535, 32767, 0, 1);
        check("sat_irq_high", int'(bus.irq), 1);
        wr(R_STATUS, 2);
        check("sat_irq_w1c", int'(bus.irq), 0);
        rd(R_STATUS, v); check("sat_status_w1c", v, 4);

        // Start and QTY write while busy are ignored; clear aborts at cycle 10.
        fill(tbl[0]);
        load_all(2);
        wr(R_POS_SEL, 0);
        wr(R_CTRL, 5);
        wr(R_CTRL, 5);
        wr(R_QTY, 999);
        repeat (7) @(negedge clk);
        wr(R_CTRL, 2);
        rd(R_STATUS, v); check("clr_status", v, 0);
        rd(R_LO, v);     check("clr_risk_lo", v, 0);
        rd(R_HI, v);     check("clr_risk_hi", v, 0);
        rd(R_CTRL, v);   check("clr_irq_en_kept", v, 4);
        run_check("rerun", 2, 35, 0, 15, 0);

        // 17-write RA burst wraps SCEN_SEL; the last write lands on scenario 0.
        wr(R_NUM_POS, 1);
        wr(R_POS_SEL, 0);
        wr(R_QTY, 1);
        wr(R_SCEN_SEL, 0);
        qty_m[0] = 1;
        for (int s = 0; s < 17; s++) begin
            wr(R_RA, (s == 16) ? 1000 : 10 * s);
            if (s < 16) ra_m[0][s] = 10 * s;
        end
        ra_m[0][0] = 1000;
        rd(R_SCEN_SEL, v); check("burst_scen_sel", v, 1);
        model(1, lo, hi, wst, ovf);
        run_check("burst", 1, lo, hi, wst, ovf);

        wr(R_NUM_POS, 0);
        run_check("np0", 0, 0, 0, 0, 0);

        for (int it = 0; it < 8; it++) begin
            np = $urandom_range(0, 10);
            for (int p = 0; p < NP; p++) begin
                qty_m[p] = (it % 2 == 1) ? int'($urandom_range(0, 65535)) - 32768
                                         : int'($urandom_range(0, 600)) - 300;
                for (int s = 0; s < NS; s++)
                    ra_m[p][s] = (it % 2 == 1) ? int'($urandom_range(0, 65535)) - 32768
                                               : int'($urandom_range(0, 600)) - 300;
            end
            load_all(np);
            model(np, lo, hi, wst, ovf);
            run_check($sformatf("rnd%0d", it), np, lo, hi, wst, ovf);
        end

        // Reset during cycle 5 of a computation.
        wr(R_NUM_POS, 8);
        wr(R_CTRL, 5);
        rd(R_CTRL, v); check("busy_ctrl_read", v, 4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_readdata", int'(bus.readData), 0);
        check("midreset_irq", int'(bus.irq), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < NP; p++) begin
            qty_m[p] = 0;
            for (int s = 0; s < NS; s++) ra_m[p][s] = 0;
        end
        rd(R_STATUS, v); check("midreset_status", v, 0);
        rd(R_LO, v);     check("midreset_risk_lo", v, 0);
        run_check("post_reset", 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
